pipe_stage_buf: RTL and testbench

- Parametrised, elastic pipeline register that replaces the fixed fetch/decode/exec stage registers.
- Carries one WIDTH-bit payload with a valid/ready handshake on both sides, plus a synchronous flush.
- Contains a 2-entry skid buffer, so in_ready is registered and full throughput holds under back-pressure.
- Sits between any two core stages, e.g. fetch→decode carrying the instruction word, or decode→exec carrying packed decode fields.

---
 rtl/pipe_stage_buf.sv | 116 +++++++++++
 tb/tb_pipe_stage_buf.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline register with a 2-entry skid buffer.
// Carries a WIDTH-bit payload with valid/ready handshakes on both sides and a
// synchronous flush. in_ready comes straight from a state flop, so the stage
// breaks the ready path and sustains one payload per cycle under back-pressure.
// Optional feature macro: PIPE_STAGE_PERF_EN adds the stall_cnt and flush_cnt
// saturating performance counters.
module pipe_stage_buf #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [31:0] BUBBLE = 32'h0000_0013,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // BUBBLE truncated or zero-extended to the payload width
  localparam logic [WIDTH-1:0] BUB = WIDTH'(BUBBLE);

  if (WIDTH < 1 || WIDTH > 256 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_buf: WIDTH must be 1..256 and CNT_W at least 1");
  end

  // Encoding chosen so bit 0 is the main-entry valid and bit 1 the skid valid;
  // 2'b10 (skid without main) is the illegal combination.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } occ_t;

  occ_t             state;
  logic [WIDTH-1:0] m_d;
  logic [WIDTH-1:0] s_d;
  logic             m_v;
  logic             s_v;
  logic             acc;
  logic             pop;

  assign m_v       = state[0];
  assign s_v       = state[1];
  assign in_ready  = !s_v;
  assign out_valid = m_v;
  assign out_data  = m_v ? m_d : BUB;
  assign acc       = in_valid & in_ready;
  assign pop       = m_v & out_ready;

  // Occupancy FSM and data registers; flush empties the stage but keeps data
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= EMPTY;
      m_d   <= BUB;
      s_d   <= BUB;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state <= ONE;
            m_d   <= in_data;
          end
        end
        ONE: begin
          if (acc && pop) begin
            m_d <= in_data;
          end else if (acc) begin
            state <= FULL;
            s_d   <= in_data;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state <= ONE;
            m_d   <= s_d;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Saturating stall and flush counters; only RST clears them
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (m_v && !out_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush && (m_v || s_v) && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif

  a_skid_needs_main: assert property (@(posedge CLK) disable iff (!RST) !(s_v && !m_v))
    else $error("pipe_stage_buf: skid entry valid while main entry empty");

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: directed vectors push their expected
// payloads into a queue, a negedge monitor pops and compares every transfer.
module tb_pipe_stage_buf;

  logic        CLK = 1'b0;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];

  pipe_stage_buf #(
    .WIDTH (32),
    .BUBBLE(32'h0000_0013),
    .CNT_W (4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every transfer (out_valid & out_ready) must match the queue head
  always @(negedge CLK) begin
    if (RST && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got %h expected no output at %0t", out_data, $time);
      end else begin
        chk("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  // Watchdog keeps the run bounded
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #11;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h13);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_STAGE_PERF_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    RST = 1'b1;

    // Idle with in_valid low
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_out_data", out_data, 32'h13);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
    end

    // Stream A0..A7 with no back-pressure
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hA0 + 32'(i));
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(i);
      tick();
      chk("strm_out_valid", 32'(out_valid), 32'd1);
      chk("strm_out_data", out_data, 32'hA0 + 32'(i));
      chk("strm_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    in_data  = 'x;
    tick();
    chk("strm_drain_valid", 32'(out_valid), 32'd0);
    chk("strm_drain_data", out_data, 32'h13);

    // Back-pressure: 11, 22 accepted, 33 held upstream
    out_ready = 1'b0;
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h33);
    in_valid = 1'b1;
    in_data  = 32'h11;
    tick();
    chk("bp_one_in_ready", 32'(in_ready), 32'd1);
    chk("bp_one_data", out_data, 32'h11);
    in_data = 32'h22;
    tick();
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_full_data", out_data, 32'h11);
    in_data = 32'h33;
    tick();
    chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_data", out_data, 32'h11);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1_in_ready", 32'(in_ready), 32'd1);
    chk("bp_pop1_data", out_data, 32'h22);
    tick();
    chk("bp_pop2_data", out_data, 32'h33);
    in_valid = 1'b0;
    tick();
    chk("bp_empty_valid", 32'(out_valid), 32'd0);

    // Flush from FULL with a same-cycle offer of 77
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    tick();
    in_data = 32'h66;
    tick();
    chk("fl_full_in_ready", 32'(in_ready), 32'd0);
    flush   = 1'b1;
    in_data = 32'h77;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_out_data", out_data, 32'h13);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_STAGE_PERF_EN
    chk("fl_flush_cnt1", 32'(flush_cnt), 32'd1);
`endif
    // Flush from ONE while accepting 99: the accept is discarded
    in_valid = 1'b1;
    in_data  = 32'h88;
    tick();
    flush   = 1'b1;
    in_data = 32'h99;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl2_out_valid", 32'(out_valid), 32'd0);
`ifdef PIPE_STAGE_PERF_EN
    chk("fl2_flush_cnt2", 32'(flush_cnt), 32'd2);
`endif
    out_ready = 1'b1;
    tick();
    tick();
    chk("fl2_still_empty", 32'(out_valid), 32'd0);

    // Async reset between edges while in ONE
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hC1;
    tick();
    in_valid = 1'b0;
    chk("ar_one_valid", 32'(out_valid), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_data", out_data, 32'h13);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    exp_q.push_back(32'hC2);
    in_valid = 1'b1;
    in_data  = 32'hC2;
    tick();
    in_valid = 1'b0;
    chk("ar_first_valid", 32'(out_valid), 32'd1);
    chk("ar_first_data", out_data, 32'hC2);
`ifdef PIPE_STAGE_PERF_EN
    chk("ar_stall_cleared", 32'(stall_cnt), 32'd0);
    chk("ar_flush_cleared", 32'(flush_cnt), 32'd0);
`endif
    out_ready = 1'b1;
    tick();
    chk("ar_drain_valid", 32'(out_valid), 32'd0);

    // Long stall after one accept: data stays put, stall counter saturates
    out_ready = 1'b0;
    exp_q.push_back(32'hD1);
    in_valid = 1'b1;
    in_data  = 32'hD1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 4 || i == 19) chk("st_hold_data", out_data, 32'hD1);
`ifdef PIPE_STAGE_PERF_EN
      if (i == 4) chk("st_stall_cnt5", 32'(stall_cnt), 32'd5);
      if (i == 19) chk("st_stall_sat", 32'(stall_cnt), 32'hF);
`endif
    end
    out_ready = 1'b1;
    tick();
    chk("st_drain_valid", 32'(out_valid), 32'd0);

    tick();
    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
